// File: rtl/mem_state_pingpong.sv
// Double-buffered recurrent state memory: per-lane ping-pong banks with a swap pulse,
// plus a clear sequencer. Define MEM_STATE_DOUT_REG_EN to add a read output register stage.
module mem_state_pingpong #(
  parameter int NUM_PE             = 16,
  parameter int ACT_INT_BW         = 8,
  parameter int ACT_FRA_BW         = 8,
  parameter int NUM_LAYER_BW       = 2,
  parameter int MEM_STATE_DEPTH_BW = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr_req,
  input  logic                             clr_all,
  input  logic [NUM_LAYER_BW-1:0]          clr_layer,
  output logic                             busy,
  input  logic                             swap,
  output logic                             bank_sel,
  input  logic                             wr_en,
  input  logic [NUM_PE-1:0]                wr_mask,
  input  logic [NUM_LAYER_BW-1:0]          wr_l_addr,
  input  logic [MEM_STATE_DEPTH_BW-1:0]    wr_addr,
  input  logic [NUM_PE*(ACT_INT_BW+ACT_FRA_BW)-1:0] wr_din,
  input  logic                             rd_en,
  input  logic                             rd_src,
  input  logic [NUM_LAYER_BW-1:0]          rd_l_addr,
  input  logic [MEM_STATE_DEPTH_BW-1:0]    rd_addr,
  output logic [NUM_PE*(ACT_INT_BW+ACT_FRA_BW)-1:0] rd_dout,
  output logic                             rd_valid
);

  localparam int ACT_BW  = ACT_INT_BW + ACT_FRA_BW;
  localparam int ADDR_BW = NUM_LAYER_BW + MEM_STATE_DEPTH_BW;
  localparam int D       = 1 << ADDR_BW;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e                     state_q, state_d;
  logic                       init_pending_q, init_pending_d;
  logic [ADDR_BW-1:0]         clr_addr_q, clr_addr_d;
  logic [ADDR_BW-1:0]         clr_end_q, clr_end_d;
  logic                       bank_sel_q, bank_sel_d;
  logic                       rd_valid_q, rd_valid_d;
  logic [NUM_PE*ACT_BW-1:0]   rd_dout_q, rd_dout_d;

  logic                       wr_fire, rd_fire, wr_bank, rd_bank;
  logic [ADDR_BW-1:0]         wr_full_addr, rd_full_addr;

  // NOTE: the state RAM has no reset; its contents are defined by the clear sweep instead,
  // which keeps it mappable onto block RAM.
  logic [ACT_BW-1:0] mem [2][NUM_PE][D];

  assign busy         = (state_q == ST_CLEAR);
  assign bank_sel     = bank_sel_q;
  assign wr_fire      = wr_en && !busy;
  assign rd_fire      = rd_en && !busy;
  assign wr_bank      = ~bank_sel_q;
  assign rd_bank      = bank_sel_q ^ rd_src;
  assign wr_full_addr = {wr_l_addr, wr_addr};
  assign rd_full_addr = {rd_l_addr, rd_addr};

  // NOTE: every variable gets its default at the top of the block so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    state_d        = state_q;
    init_pending_d = init_pending_q;
    clr_addr_d     = clr_addr_q;
    clr_end_d      = clr_end_q;
    bank_sel_d     = bank_sel_q;
    rd_valid_d     = rd_fire;
    rd_dout_d      = rd_dout_q;

    unique case (state_q)
      ST_IDLE: begin
        // A pending post-reset clear or a request both win over a same-cycle swap.
        if (clr_req || init_pending_q) begin
          state_d        = ST_CLEAR;
          init_pending_d = 1'b0;
          if (clr_all || init_pending_q) begin
            clr_addr_d = '0;
            clr_end_d  = '1;
            bank_sel_d = 1'b0;
          end else begin
            clr_addr_d = {clr_layer, {MEM_STATE_DEPTH_BW{1'b0}}};
            clr_end_d  = {clr_layer, {MEM_STATE_DEPTH_BW{1'b1}}};
          end
        end else if (swap) begin
          bank_sel_d = ~bank_sel_q;
        end
      end
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == clr_end_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rd_fire) begin
      for (int i = 0; i < NUM_PE; i++) begin
        rd_dout_d[i*ACT_BW +: ACT_BW] = mem[rd_bank][i][rd_full_addr];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values; this is also what makes a same-cycle read return the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      init_pending_q <= 1'b1;
      clr_addr_q     <= '0;
      clr_end_q      <= '0;
      bank_sel_q     <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_dout_q      <= '0;
    end else begin
      state_q        <= state_d;
      init_pending_q <= init_pending_d;
      clr_addr_q     <= clr_addr_d;
      clr_end_q      <= clr_end_d;
      bank_sel_q     <= bank_sel_d;
      rd_valid_q     <= rd_valid_d;
      rd_dout_q      <= rd_dout_d;
    end
  end

  // The sweep zeroes both banks of every lane; user writes only reach the next bank.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NUM_PE; i++) begin
        if (busy) begin
          mem[b][i][clr_addr_q] <= '0;
        end else if (wr_fire && wr_mask[i] && (b == int'(wr_bank))) begin
          mem[b][i][wr_full_addr] <= wr_din[i*ACT_BW +: ACT_BW];
        end
      end
    end
  end

`ifdef MEM_STATE_DOUT_REG_EN
  logic                     rd_valid2_q, rd_valid2_d;
  logic [NUM_PE*ACT_BW-1:0] rd_dout2_q, rd_dout2_d;

  // Reads already in flight keep draining even if a clear starts behind them.
  always_comb begin
    rd_valid2_d = rd_valid_q;
    rd_dout2_d  = rd_valid_q ? rd_dout_q : rd_dout2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid2_q <= 1'b0;
      rd_dout2_q  <= '0;
    end else begin
      rd_valid2_q <= rd_valid2_d;
      rd_dout2_q  <= rd_dout2_d;
    end
  end

  assign rd_valid = rd_valid2_q;
  assign rd_dout  = rd_dout2_q;
`else
  assign rd_valid = rd_valid_q;
  assign rd_dout  = rd_dout_q;
`endif

endmodule

// File: tb/tb_mem_state_pingpong.sv
// Directed bench for mem_state_pingpong (4 lanes, 8.8 words, 2 layers x 4 words, D=8).
module tb_mem_state_pingpong;
  localparam int NUM_PE = 4;
  localparam int ACT_BW = 16;
`ifdef MEM_STATE_DOUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk, rst, clr_req, clr_all, busy, swap, bank_sel;
  logic [0:0]  clr_layer, wr_l_addr, rd_l_addr;
  logic        wr_en, rd_en, rd_src, rd_valid;
  logic [3:0]  wr_mask;
  logic [1:0]  wr_addr, rd_addr;
  logic [63:0] wr_din, rd_dout;

  int errors = 0;
  int checks = 0;

  mem_state_pingpong #(
    .NUM_PE(NUM_PE), .ACT_INT_BW(8), .ACT_FRA_BW(8),
    .NUM_LAYER_BW(1), .MEM_STATE_DEPTH_BW(2)
  ) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_all(clr_all), .clr_layer(clr_layer),
    .busy(busy), .swap(swap), .bank_sel(bank_sel), .wr_en(wr_en), .wr_mask(wr_mask),
    .wr_l_addr(wr_l_addr), .wr_addr(wr_addr), .wr_din(wr_din), .rd_en(rd_en),
    .rd_src(rd_src), .rd_l_addr(rd_l_addr), .rd_addr(rd_addr), .rd_dout(rd_dout),
    .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] lanes(input logic [15:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [63:0] pat(input int a);
    logic [15:0] v;
    v = 16'h1100 + 16'(a * 16);
    return lanes(v, v + 16'd1, v + 16'd2, v + 16'd3);
  endfunction

  task automatic do_write(input int addr, input logic [3:0] mask, input logic [63:0] data);
    wr_en = 1'b1; wr_mask = mask; wr_l_addr = addr[2]; wr_addr = addr[1:0]; wr_din = data;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic src, input int addr, input logic [63:0] exp);
    string tag;
    tag = $sformatf("rd_src%0d_addr%0d", src, addr);
    rd_en = 1'b1; rd_src = src; rd_l_addr = addr[2]; rd_addr = addr[1:0];
    step();
    rd_en = 1'b0;
    repeat (LAT - 1) step();
    check({tag, "_valid"}, 64'(rd_valid), 64'd1);
    check(tag, rd_dout, exp);
  endtask

  // Waits (bounded) for busy to rise, then counts the cycles it stays high.
  task automatic count_busy(output int n, output bit rose);
    int g;
    g = 0;
    n = 0;
    while (!busy && g < 4) begin step(); g++; end
    rose = busy;
    while (busy && n < 40) begin n++; step(); end
  endtask

  initial begin
    int  n, nbusy, nvalid;
    bit  rose;
    logic [63:0] s_dout [3];
    logic        s_valid [3];

    rst = 1'b1; clr_req = 1'b0; clr_all = 1'b0; clr_layer = 1'b0; swap = 1'b0;
    wr_en = 1'b0; wr_mask = '0; wr_l_addr = '0; wr_addr = '0; wr_din = '0;
    rd_en = 1'b0; rd_src = 1'b0; rd_l_addr = '0; rd_addr = '0;
    step(); step();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_bank_sel", 64'(bank_sel), 64'd0);
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_rd_dout", rd_dout, 64'd0);

    // Post-reset full clear.
    rst = 1'b0;
    count_busy(n, rose);
    check("init_clear_rose", 64'(rose), 64'd1);
    check("init_clear_len", 64'(n), 64'd8);
    for (int a = 0; a < 8; a++) begin
      do_read(1'b0, a, 64'd0);
      do_read(1'b1, a, 64'd0);
    end

    // Masked write into the next bank, then swap makes it the prev bank.
    do_write(3, 4'b0101, lanes(16'h0100, 16'h0100, 16'h0100, 16'h0100));
    swap = 1'b1; step(); swap = 1'b0;
    check("swap_bank_sel", 64'(bank_sel), 64'd1);
    do_read(1'b0, 3, lanes(16'h0100, 16'h0000, 16'h0100, 16'h0000));
    do_read(1'b1, 3, 64'd0);

    // Same-cycle write/read at addr 5 (read-first), then the same read one cycle later.
    wr_en = 1'b1; wr_mask = 4'b1111; wr_l_addr = 1'b1; wr_addr = 2'd1;
    wr_din = lanes(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    rd_en = 1'b1; rd_src = 1'b1; rd_l_addr = 1'b1; rd_addr = 2'd1;
    step(); s_dout[0] = rd_dout; s_valid[0] = rd_valid;
    wr_en = 1'b0;
    step(); s_dout[1] = rd_dout; s_valid[1] = rd_valid;
    rd_en = 1'b0;
    step(); s_dout[2] = rd_dout; s_valid[2] = rd_valid;
    check("collide_old_valid", 64'(s_valid[LAT-1]), 64'd1);
    check("collide_old_data", s_dout[LAT-1], 64'd0);
    check("collide_new_valid", 64'(s_valid[LAT]), 64'd1);
    check("collide_new_data", s_dout[LAT], lanes(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF));

    // Fill the next bank, clear layer 1 only; inputs change after acceptance.
    for (int a = 0; a < 8; a++) do_write(a, 4'b1111, pat(a));
    clr_req = 1'b1; clr_all = 1'b0; clr_layer = 1'b1;
    step();
    clr_req = 1'b0; clr_all = 1'b1; clr_layer = 1'b0;
    count_busy(n, rose);
    check("layer_clear_rose", 64'(rose), 64'd1);
    check("layer_clear_len", 64'(n), 64'd4);
    check("layer_clear_bank_sel", 64'(bank_sel), 64'd1);
    for (int a = 0; a < 8; a++) do_read(1'b1, a, (a < 4) ? pat(a) : 64'd0);
    do_read(1'b0, 3, lanes(16'h0100, 16'h0000, 16'h0100, 16'h0000));

    // Swap with a full clear request; traffic during busy must be ignored.
    clr_req = 1'b1; clr_all = 1'b1; swap = 1'b1;
    step();
    clr_req = 1'b0; swap = 1'b0;
    nbusy = 0; nvalid = 0;
    for (int k = 0; k < 12; k++) begin
      nbusy += int'(busy);
      nvalid += int'(rd_valid);
      wr_en = (k == 2); wr_mask = 4'b1111; wr_l_addr = 1'b0; wr_addr = 2'd0;
      wr_din = lanes(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      rd_en = (k == 3); rd_src = 1'b0; rd_l_addr = 1'b0; rd_addr = 2'd0;
      swap  = (k == 4);
      step();
    end
    wr_en = 1'b0; rd_en = 1'b0; swap = 1'b0;
    check("full_clear_len", 64'(nbusy), 64'd8);
    check("busy_rd_valid_count", 64'(nvalid), 64'd0);
    check("full_clear_bank_sel", 64'(bank_sel), 64'd0);
    do_read(1'b0, 0, 64'd0);
    do_read(1'b1, 0, 64'd0);
    do_read(1'b1, 3, 64'd0);

    // Reset at clear cycle 3 restarts a complete sweep after release.
    do_write(6, 4'b1111, pat(6));
    clr_req = 1'b1; clr_all = 1'b1;
    step();
    clr_req = 1'b0;
    step(); step();
    rst = 1'b1;
    step(); step();
    check("midclear_reset_busy", 64'(busy), 64'd0);
    check("midclear_reset_bank_sel", 64'(bank_sel), 64'd0);
    rst = 1'b0;
    count_busy(n, rose);
    check("restart_clear_rose", 64'(rose), 64'd1);
    check("restart_clear_len", 64'(n), 64'd8);
    do_read(1'b1, 6, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
